// File: rtl/uart_frame_parser_if.sv
// Byte-level signals between the parser, the upstream receive FIFO and the
// downstream payload consumer. The parser uses the master view.
interface uart_frame_parser_if;
    logic       empty;
    logic [7:0] r_data;
    logic       rd;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        input  empty, r_data, out_ready,
        output rd, out_valid, out_data, out_last
    );

    modport slave (
        output empty, r_data, out_ready,
        input  rd, out_valid, out_data, out_last
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CHK frames popped from the receive FIFO, validates
// length and checksum, and releases good payloads as a valid/ready byte stream.
module uart_frame_parser #(
    parameter logic [7:0]  SOF     = 8'hA5,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic                clk,
    input  logic                reset,
    uart_frame_parser_if.master bus,
    output logic                frame_ok,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [7:0]          err_count
);
    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, SEND} state_e;

    localparam int unsigned IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_e      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] idle_q, idle_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        frame_ok_q, frame_ok_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [7:0]  pbuf_q [2**IW];

    logic        pop;
    logic        buf_we;
    logic [7:0]  nidx;
    logic [7:0]  chk_sum;

    // Popping stops entirely in SEND so the FIFO absorbs any backlog.
    assign pop = !reset && !bus.empty && (state_q != SEND);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        idle_d      = idle_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        err_d       = 1'b0;
        err_code_d  = 2'd0;
        err_count_d = err_count_q;
        buf_we      = 1'b0;
        nidx        = idx_q + 8'd1;
        chk_sum     = sum_q + bus.r_data;

        case (state_q)
            HUNT: begin
                idle_d = '0;
                if (pop && bus.r_data == SOF) state_d = LEN;
            end
            LEN: begin
                if (pop) begin
                    len_d  = bus.r_data;
                    sum_d  = bus.r_data;
                    idle_d = '0;
                    if (bus.r_data == 8'd0 || bus.r_data > MAX_LEN_B) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = HUNT;
                    end else begin
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + bus.r_data;
                    idx_d  = nidx;
                    idle_d = '0;
                    if (nidx == len_q) state_d = CHK;
                end
            end
            CHK: begin
                if (pop) begin
                    idle_d = '0;
                    if (chk_sum == 8'd0) begin
                        frame_ok_d  = 1'b1;
                        idx_d       = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = pbuf_q[0];
                        out_last_d  = (len_q == 8'd1);
                        state_d     = SEND;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                        state_d    = HUNT;
                    end
                end
            end
            SEND: begin
                idle_d = '0;
                // The next byte is staged on the transfer edge so out_data is already registered.
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = HUNT;
                    end else begin
                        idx_d      = nidx;
                        out_data_d = pbuf_q[nidx[IW-1:0]];
                        out_last_d = (nidx == len_q - 8'd1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (TIMEOUT > 0 && !pop && (state_q == LEN || state_q == PAYLOAD || state_q == CHK)) begin
            if (idle_q + 32'd1 == TIMEOUT) begin
                err_d      = 1'b1;
                err_code_d = 2'd3;
                idle_d     = '0;
                state_d    = HUNT;
            end else begin
                idle_d = idle_q + 32'd1;
            end
        end

        if (err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            len_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            idle_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            idle_q      <= idle_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) pbuf_q[idx_q[IW-1:0]] <= bus.r_data;
    end

    assign bus.rd        = pop;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign frame_ok      = frame_ok_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign err_count     = err_count_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed scenarios plus random byte chunks
// checked against a frame-level reference parser of the pushed byte stream.
module tb_uart_frame_parser;
    localparam logic [7:0] SOF     = 8'hA5;
    localparam int         MAX_LEN = 16;
    localparam int         TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_ok, err;
    logic [1:0] err_code;
    logic [7:0] err_count;

    uart_frame_parser_if bus();

    uart_frame_parser #(.SOF(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(rst), .bus(bus),
        .frame_ok(frame_ok), .err(err), .err_code(err_code), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] fifo[$];
    logic [7:0] chunk[$];
    int         exp_ev[$], got_ev[$], exp_out[$], got_out[$], xfer_cyc[$];
    int         exp_errs = 0;
    int         cyc = 0, last_pop_cyc = 0, ok_cyc = 0, n_pops = 0;
    int         ready_mode = 0;
    bit         pop_pending = 0, prev_valid = 0, prev_xfer = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // FIFO model and monitor: inputs change on the falling edge, outputs sampled there too.
    always @(negedge clk) begin
        if (rst) begin
            pop_pending = 0;
            prev_valid  = 0;
            bus.empty   = 1'b1;
            bus.r_data  = 8'h00;
        end else begin
            cyc++;
            if (pop_pending) void'(fifo.pop_front());
            if (frame_ok) begin
                check_eq("ok_latency", cyc - last_pop_cyc, 1);
                check_eq("ok_first_valid", int'(bus.out_valid), 1);
                check_eq("ok_err_exclusive", int'(err), 0);
                got_ev.push_back(0);
                ok_cyc = cyc;
            end
            if (err) begin
                check_eq("err_latency", cyc - last_pop_cyc, (err_code == 2'd3) ? TIMEOUT + 1 : 1);
                got_ev.push_back(int'(err_code));
            end
            if (prev_valid && !prev_xfer) begin
                check_eq("hold_valid", int'(bus.out_valid), 1);
                check_eq("hold_data", int'(bus.out_data), int'(prev_data));
                check_eq("hold_last", int'(bus.out_last), int'(prev_last));
            end
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
            bus.empty  = (fifo.size() == 0);
            bus.r_data = bus.empty ? 8'h00 : fifo[0];
            #1;
            pop_pending = bus.rd;
            if (bus.rd) begin
                last_pop_cyc = cyc;
                n_pops++;
                check_eq("rd_while_empty", int'(bus.empty), 0);
                check_eq("rd_during_send", int'(bus.out_valid), 0);
            end
            prev_xfer = bus.out_valid && bus.out_ready;
            if (prev_xfer) begin
                got_out.push_back(int'({bus.out_last, bus.out_data}));
                xfer_cyc.push_back(cyc);
            end
            prev_valid = bus.out_valid;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic exp_err(input int code);
        exp_ev.push_back(code);
        if (exp_errs < 255) exp_errs++;
    endtask

    // Reference: walk the byte stream frame by frame; an unfinished frame at the
    // end of a chunk is followed by a long idle gap and must time out.
    task automatic model_chunk();
        int i = 0;
        int n = chunk.size();
        int len;
        logic [7:0] s;
        while (i < n) begin
            if (chunk[i] != SOF) begin i++; continue; end
            if (i + 1 >= n) begin exp_err(3); break; end
            len = int'(chunk[i+1]);
            if (len == 0 || len > MAX_LEN) begin exp_err(1); i += 2; continue; end
            if (i + 2 + len >= n) begin exp_err(3); break; end
            s = 8'h00;
            for (int k = 1; k <= len + 2; k++) s += chunk[i+k];
            if (s == 8'h00) begin
                exp_ev.push_back(0);
                for (int k = 0; k < len; k++)
                    exp_out.push_back(((k == len - 1) ? 256 : 0) + int'(chunk[i+2+k]));
            end else begin
                exp_err(2);
            end
            i += len + 3;
        end
    endtask

    task automatic put_bytes(input logic [63:0] v, input int n);
        for (int k = 0; k < n; k++) chunk.push_back(v[8*(n-1-k) +: 8]);
    endtask

    task automatic put_frame(input int len, input bit corrupt);
        logic [7:0] s, b;
        chunk.push_back(SOF);
        chunk.push_back(8'(len));
        s = 8'(len);
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            chunk.push_back(b);
            s += b;
        end
        s = -s;
        if (corrupt) s += 8'($urandom_range(1, 255));
        chunk.push_back(s);
    endtask

    task automatic send_chunk();
        model_chunk();
        xfer_cyc.delete();
        n_pops = 0;
        foreach (chunk[k]) fifo.push_back(chunk[k]);
        chunk.delete();
    endtask

    task automatic finish_chunk(input string tag);
        int w = 0;
        while (!(fifo.size() == 0 && !bus.out_valid && !pop_pending) && w < 5000) begin
            @(negedge clk); #2;
            w++;
        end
        check_eq({tag, "_drained_in_budget"}, int'(w < 5000), 1);
        repeat (TIMEOUT + 5) @(negedge clk);
        #2;
        check_eq({tag, "_n_events"}, got_ev.size(), exp_ev.size());
        for (int k = 0; k < exp_ev.size() && k < got_ev.size(); k++)
            check_eq({tag, "_event"}, got_ev[k], exp_ev[k]);
        check_eq({tag, "_n_bytes"}, got_out.size(), exp_out.size());
        for (int k = 0; k < exp_out.size() && k < got_out.size(); k++)
            check_eq({tag, "_byte"}, got_out[k], exp_out[k]);
        check_eq({tag, "_err_count"}, int'(err_count), exp_errs);
        got_ev.delete(); exp_ev.delete(); got_out.delete(); exp_out.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd"}, int'(bus.rd), 0);
        check_eq({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check_eq({tag, "_out_last"}, int'(bus.out_last), 0);
        check_eq({tag, "_out_data"}, int'(bus.out_data), 0);
        check_eq({tag, "_frame_ok"}, int'(frame_ok), 0);
        check_eq({tag, "_err"}, int'(err), 0);
        check_eq({tag, "_err_code"}, int'(err_code), 0);
        check_eq({tag, "_err_count"}, int'(err_count), 0);
    endtask

    initial begin
        int w;
        int kind;
        int len;
        logic [7:0] b;
        bus.empty     = 1'b1;
        bus.r_data    = 8'h00;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check_all_zero("reset");
        rst = 1'b0;

        put_bytes(64'hA5_03_11_22_33_97, 6);
        send_chunk();
        finish_chunk("good");
        check_eq("good_pops", n_pops, 6);
        check_eq("good_n_xfers", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            check_eq("good_first_xfer_cycle", xfer_cyc[0], ok_cyc);
            check_eq("good_last_xfer_cycle", xfer_cyc[2], ok_cyc + 2);
        end

        put_bytes(64'hA5_03_11_22_33_98, 6);
        send_chunk();
        finish_chunk("bad_chk");

        put_bytes(64'h00_FF_A5_00_A5_11, 6);
        send_chunk();
        finish_chunk("bad_len");

        put_bytes(64'hA5_03_11, 3);
        send_chunk();
        finish_chunk("timeout");
        put_bytes(64'hA5_01_5A_A5, 4);
        send_chunk();
        finish_chunk("after_timeout");

        ready_mode = 2;
        put_bytes(64'hA5_02_AA_BB_99, 5);
        put_bytes(64'hA5_01_5A_A5, 4);
        send_chunk();
        w = 0;
        while (got_ev.size() == 0 && w < 200) begin @(negedge clk); #2; w++; end
        repeat (10) @(negedge clk);
        #2;
        check_eq("bp_fifo_backlog", fifo.size(), 4);
        check_eq("bp_valid", int'(bus.out_valid), 1);
        check_eq("bp_data", int'(bus.out_data), 8'hAA);
        check_eq("bp_last", int'(bus.out_last), 0);
        ready_mode = 0;
        finish_chunk("backpressure");

        put_bytes(64'hA5_03_11, 3);
        send_chunk();
        w = 0;
        while (n_pops < 3 && w < 200) begin @(negedge clk); #2; w++; end
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        fifo.delete();
        exp_ev.delete(); got_ev.delete(); exp_out.delete(); got_out.delete();
        exp_errs = 0;
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b0;
        put_bytes(64'hA5_02_CC_DD_55, 5);
        send_chunk();
        finish_chunk("after_reset");

        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
                kind = int'($urandom_range(0, 3));
                case (kind)
                    0: put_frame(int'($urandom_range(1, MAX_LEN)), 1'b0);
                    1: put_frame(int'($urandom_range(1, MAX_LEN)), 1'b1);
                    2: begin
                        chunk.push_back(SOF);
                        chunk.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
                    end
                    default: begin
                        b = 8'($urandom);
                        chunk.push_back((b == SOF) ? 8'h00 : b);
                    end
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                chunk.push_back(SOF);
                if ($urandom_range(0, 1) == 1) begin
                    len = int'($urandom_range(1, MAX_LEN));
                    chunk.push_back(8'(len));
                    for (int k = 0; k < int'($urandom_range(0, len)); k++) chunk.push_back(8'($urandom));
                end
            end
            send_chunk();
            finish_chunk("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
